// File: rtl/snake_body_ctrl.sv
// Snake body controller: owns an external DEPTH-deep recirculating shift register,
// initialises it, inserts new head segments on request and streams the body out.
module snake_body_ctrl #(
  parameter int              WIDTH    = 2,
  parameter int              DEPTH    = 234,
  parameter int              INIT_LEN = 3,
  parameter logic [WIDTH-1:0] INIT_DIR = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [WIDTH-1:0]           sr_in,
  input  logic [WIDTH-1:0]           sr_out,
  input  logic                       move_req,
  input  logic [WIDTH-1:0]           move_dir,
  input  logic                       move_grow,
  output logic                       move_ack,
  output logic                       move_done,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] length,
  output logic                       full,
  output logic                       seg_valid,
  output logic                       seg_first,
  output logic [WIDTH-1:0]           seg_dir
);
  localparam int              LW         = $clog2(DEPTH + 1);
  localparam int              PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   LAST_POS   = PW'(DEPTH - 1);
  localparam logic [LW-1:0]   DEPTH_L    = LW'(DEPTH);
  localparam logic [LW-1:0]   INIT_LEN_L = LW'(INIT_LEN);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ARMED} state_t;

  state_t            state_reg;
  logic [PW-1:0]     pos_reg, pos_next;
  logic [PW-1:0]     head_reg, head_upd, target_reg, target_calc;
  logic [LW-1:0]     len_reg, len_upd, scan_left_reg;
  logic [WIDTH-1:0]  dir_reg;
  logic              grow_reg, grow_ok;
  logic              done_reg, busy_reg, full_reg;
  logic              seg_valid_reg, seg_first_reg;
  logic              write_slot, run_next;

  assign pos_next    = (pos_reg == LAST_POS) ? '0 : pos_reg + PW'(1);
  assign target_calc = (head_reg == '0) ? LAST_POS : head_reg - PW'(1);
  assign write_slot  = (state_reg == S_ARMED) && (pos_reg == target_reg);
  assign grow_ok     = grow_reg && !full_reg;
  assign head_upd    = write_slot ? target_reg : head_reg;
  assign len_upd     = (write_slot && grow_ok) ? len_reg + LW'(1) : len_reg;
  assign run_next    = (state_reg != S_INIT) || (pos_reg == LAST_POS);

  assign move_ack  = (state_reg == S_IDLE) && move_req;
  assign move_done = done_reg;
  assign busy      = busy_reg;
  assign length    = len_reg;
  assign full      = full_reg;
  assign seg_valid = seg_valid_reg;
  assign seg_first = seg_first_reg;
  assign seg_dir   = sr_out;

  // Recirculate by default so the ring keeps its contents; override only at the write slot.
  always_comb begin
    sr_in = sr_out;
    if (!rst_n)
      sr_in = '0;
    else if (state_reg == S_INIT)
      sr_in = INIT_DIR;
    else if (write_slot)
      sr_in = dir_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pos_reg <= '0;
    else
      pos_reg <= pos_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_INIT;
      head_reg   <= '0;
      len_reg    <= INIT_LEN_L;
      target_reg <= '0;
      dir_reg    <= '0;
      grow_reg   <= 1'b0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b1;
      full_reg   <= (INIT_LEN == DEPTH);
    end else begin
      done_reg <= write_slot;
      head_reg <= head_upd;
      len_reg  <= len_upd;
      full_reg <= (len_upd == DEPTH_L);
      case (state_reg)
        S_INIT: if (pos_reg == LAST_POS) begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
        S_IDLE: if (move_req) begin
          state_reg  <= S_ARMED;
          busy_reg   <= 1'b1;
          target_reg <= target_calc;
          dir_reg    <= move_dir;
          grow_reg   <= move_grow;
        end
        S_ARMED: if (pos_reg == target_reg) begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= S_INIT;
          busy_reg  <= 1'b1;
        end
      endcase
    end
  end

  // Scan flags are computed one cycle ahead from the values the registers take on this edge,
  // so seg_valid lines up with the cycle in which pos equals the registered head pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_valid_reg <= 1'b0;
      seg_first_reg <= 1'b0;
      scan_left_reg <= '0;
    end else if (!run_next) begin
      seg_valid_reg <= 1'b0;
      seg_first_reg <= 1'b0;
      scan_left_reg <= '0;
    end else if (seg_valid_reg && (scan_left_reg != '0)) begin
      seg_valid_reg <= 1'b1;
      seg_first_reg <= 1'b0;
      scan_left_reg <= scan_left_reg - LW'(1);
    end else if (pos_next == head_upd) begin
      seg_valid_reg <= 1'b1;
      seg_first_reg <= 1'b1;
      scan_left_reg <= len_upd - LW'(1);
    end else begin
      seg_valid_reg <= 1'b0;
      seg_first_reg <= 1'b0;
      scan_left_reg <= '0;
    end
  end
endmodule

// File: tb/tb_snake_body_ctrl.sv
// Bench for snake_body_ctrl: two instances (short body, full body) share move inputs and
// each drives its own DEPTH-latency ring; a queue-based body model predicts every output.
module tb_snake_body_ctrl;
  localparam int D = 234;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       move_req = 1'b0;
  logic [1:0] move_dir = 2'd0;
  logic       move_grow = 1'b0;

  logic [1:0] sr_in [2];
  logic [1:0] sr_out [2];
  logic [1:0] seg_dir [2];
  logic       move_ack [2];
  logic       move_done [2];
  logic       busy [2];
  logic       full [2];
  logic       seg_valid [2];
  logic       seg_first [2];
  logic [7:0] length [2];

  int compared = 0;
  int mismatched = 0;
  int cyc;

  logic [1:0] ring0 [D];
  logic [1:0] ring1 [D];
  int         rp = 0;

  // Reference model: body as a head-first list of direction codes.
  logic [1:0] body0 [$];
  logic [1:0] body1 [$];
  int         m_head, m_tgt, m_write_cyc, m_done_cyc, m_idle_cyc;
  logic [1:0] m_dir;
  logic       m_grow;

  always #5 clk = ~clk;

  snake_body_ctrl dut_small (
    .clk(clk), .rst_n(rst_n), .sr_in(sr_in[0]), .sr_out(sr_out[0]),
    .move_req(move_req), .move_dir(move_dir), .move_grow(move_grow),
    .move_ack(move_ack[0]), .move_done(move_done[0]), .busy(busy[0]),
    .length(length[0]), .full(full[0]), .seg_valid(seg_valid[0]),
    .seg_first(seg_first[0]), .seg_dir(seg_dir[0])
  );

  snake_body_ctrl #(.WIDTH(2), .DEPTH(D), .INIT_LEN(D), .INIT_DIR(2'd1)) dut_full (
    .clk(clk), .rst_n(rst_n), .sr_in(sr_in[1]), .sr_out(sr_out[1]),
    .move_req(move_req), .move_dir(move_dir), .move_grow(move_grow),
    .move_ack(move_ack[1]), .move_done(move_done[1]), .busy(busy[1]),
    .length(length[1]), .full(full[1]), .seg_valid(seg_valid[1]),
    .seg_first(seg_first[1]), .seg_dir(seg_dir[1])
  );

  assign sr_out[0] = ring0[rp];
  assign sr_out[1] = ring1[rp];

  always @(posedge clk) begin
    ring0[rp] <= sr_in[0];
    ring1[rp] <= sr_in[1];
    rp <= (rp + 1) % D;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic model_reset();
    body0.delete();
    body1.delete();
    repeat (3) body0.push_back(2'd0);
    repeat (D) body1.push_back(2'd1);
    m_head = 0;
    m_idle_cyc = D;
  endtask

  task automatic model_accept(input logic [1:0] d, input logic g);
    int p, delta;
    p = cyc % D;
    m_dir = d;
    m_grow = g;
    m_tgt = (m_head + D - 1) % D;
    delta = (m_tgt - p + D) % D;
    if (delta == 0) delta = D;
    m_write_cyc = cyc + delta;
    m_done_cyc = m_write_cyc + 1;
    m_idle_cyc = m_done_cyc;
  endtask

  task automatic model_commit();
    m_head = m_tgt;
    body0.push_front(m_dir);
    if (!m_grow || body0.size() > D) void'(body0.pop_back());
    body1.push_front(m_dir);
    if (!m_grow || body1.size() > D) void'(body1.pop_back());
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    move_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (busy[i] !== 1'b1 || sr_in[i] !== 2'd0 || move_ack[i] !== 1'b0 || move_done[i] !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_ctrl[%0d]: busy=%b sr_in=%0d ack=%b done=%b want 1 0 0 0", i, busy[i], sr_in[i], move_ack[i], move_done[i]);
      end
      compared++;
      if (seg_valid[i] !== 1'b0 || seg_first[i] !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_seg[%0d]: valid=%b first=%b want 0 0", i, seg_valid[i], seg_first[i]);
      end
      compared++;
      if (length[i] !== ((i == 1) ? 8'd234 : 8'd3) || full[i] !== (i == 1)) begin
        mismatched++;
        $display("FAIL reset_len[%0d]: length=%0d full=%b", i, length[i], full[i]);
      end
    end
    move_req = 1'b0;
  endtask

  task automatic test_init();
    @(negedge clk);
    rst_n = 1'b1;
    move_req = 1'b1;
    move_dir = 2'd3;
    #1;
    for (int c = 0; c < D; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (c == D - 1) move_req = 1'b0;
        #1;
      end
      for (int i = 0; i < 2; i++) begin
        compared++;
        if (busy[i] !== 1'b1 || sr_in[i] !== ((i == 1) ? 2'd1 : 2'd0) || seg_valid[i] !== 1'b0 || move_ack[i] !== 1'b0) begin
          mismatched++;
          $display("FAIL init_cycle[%0d] c=%0d: busy=%b sr_in=%0d valid=%b ack=%b", i, c, busy[i], sr_in[i], seg_valid[i], move_ack[i]);
        end
      end
    end
    @(negedge clk);
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (busy[i] !== 1'b0 || sr_in[i] !== sr_out[i]) begin
        mismatched++;
        $display("FAIL init_exit[%0d]: busy=%b sr_in=%0d sr_out=%0d want busy 0 and recirculate", i, busy[i], sr_in[i], sr_out[i]);
      end
      compared++;
      if (length[i] !== ((i == 1) ? 8'd234 : 8'd3) || full[i] !== (i == 1)) begin
        mismatched++;
        $display("FAIL init_len[%0d]: length=%0d full=%b", i, length[i], full[i]);
      end
    end
  endtask

  task automatic test_idle_scan();
    int p;
    for (int k = 0; k < 2 * D; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      p = cyc % D;
      compared++;
      if (seg_valid[0] !== (p < 3) || seg_first[0] !== (p == 0) || (p < 3 && seg_dir[0] !== 2'd0)) begin
        mismatched++;
        $display("FAIL idle_scan_small pos=%0d: valid=%b first=%b dir=%0d", p, seg_valid[0], seg_first[0], seg_dir[0]);
      end
      compared++;
      if (seg_valid[1] !== 1'b1 || seg_first[1] !== (p == 0) || seg_dir[1] !== 2'd1) begin
        mismatched++;
        $display("FAIL idle_scan_full pos=%0d: valid=%b first=%b dir=%0d", p, seg_valid[1], seg_first[1], seg_dir[1]);
      end
    end
  endtask

  task automatic issue_move(input logic [1:0] d, input logic g);
    bit got;
    bit want;
    got = 1'b0;
    @(negedge clk);
    move_req = 1'b1;
    move_dir = d;
    move_grow = g;
    #1;
    for (int k = 0; k < 2 * D + 4 && !got; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      want = (cyc >= m_idle_cyc);
      compared++;
      if (move_ack[0] !== want || move_ack[1] !== want) begin
        mismatched++;
        $display("FAIL move_ack cyc=%0d: got %b/%b want %b", cyc, move_ack[0], move_ack[1], want);
      end
      if (move_ack[0] === 1'b1) begin
        got = 1'b1;
        model_accept(d, g);
      end
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL move_ack_timeout: got no ack want ack within %0d cycles", 2 * D + 4);
    end
  endtask

  task automatic finish_move(input bit keep, input logic [1:0] d2, input logic g2);
    for (int k = 0; k < D + 2 && cyc < m_done_cyc; k++) begin
      @(negedge clk);
      if (keep) begin
        move_dir = d2;
        move_grow = g2;
      end else begin
        move_req = 1'b0;
      end
      #1;
      if (cyc < m_done_cyc) begin
        for (int i = 0; i < 2; i++) begin
          compared++;
          if (move_done[i] !== 1'b0 || move_ack[i] !== 1'b0 || busy[i] !== 1'b1 ||
              sr_in[i] !== ((cyc == m_write_cyc) ? m_dir : sr_out[i])) begin
            mismatched++;
            $display("FAIL armed[%0d] pos=%0d: done=%b ack=%b busy=%b sr_in=%0d sr_out=%0d write_pos=%0d dir=%0d",
                     i, cyc % D, move_done[i], move_ack[i], busy[i], sr_in[i], sr_out[i], m_write_cyc % D, m_dir);
          end
        end
      end else begin
        model_commit();
        compared++;
        if (move_done[0] !== 1'b1 || move_done[1] !== 1'b1 || busy[0] !== 1'b0 || busy[1] !== 1'b0 ||
            move_ack[0] !== move_req || move_ack[1] !== move_req) begin
          mismatched++;
          $display("FAIL move_done pos=%0d: done=%b/%b busy=%b/%b ack=%b/%b want done 1 busy 0 ack %b",
                   cyc % D, move_done[0], move_done[1], busy[0], busy[1], move_ack[0], move_ack[1], move_req);
        end
        compared++;
        if (length[0] !== 8'(body0.size()) || length[1] !== 8'(body1.size()) ||
            full[0] !== (body0.size() == D) || full[1] !== (body1.size() == D)) begin
          mismatched++;
          $display("FAIL move_len: length=%0d/%0d full=%b/%b want %0d/%0d", length[0], length[1],
                   full[0], full[1], body0.size(), body1.size());
        end
      end
    end
  endtask

  task automatic check_scan(input int inst);
    bit found;
    int n;
    logic [1:0] want;
    found = 1'b0;
    for (int k = 0; k < 2 * D + 2 && !found; k++) begin
      @(negedge clk);
      #1;
      if (seg_first[inst] === 1'b1) found = 1'b1;
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL scan_timeout[%0d]: got no seg_first want one within %0d cycles", inst, 2 * D + 2);
    end else begin
      compared++;
      if ((cyc % D) != m_head) begin
        mismatched++;
        $display("FAIL scan_start[%0d]: got pos %0d want pos %0d", inst, cyc % D, m_head);
      end
      n = (inst == 1) ? body1.size() : body0.size();
      for (int j = 0; j < n; j++) begin
        if (j > 0) begin
          @(negedge clk);
          #1;
        end
        want = (inst == 1) ? body1[j] : body0[j];
        compared++;
        if (seg_valid[inst] !== 1'b1 || seg_first[inst] !== (j == 0) || seg_dir[inst] !== want) begin
          mismatched++;
          $display("FAIL scan_seg[%0d] #%0d: valid=%b first=%b dir=%0d want 1 %b %0d", inst, j,
                   seg_valid[inst], seg_first[inst], seg_dir[inst], j == 0, want);
        end
      end
      if (n < D) begin
        @(negedge clk);
        #1;
        compared++;
        if (seg_valid[inst] !== 1'b0) begin
          mismatched++;
          $display("FAIL scan_end[%0d]: got valid %b want 0 after %0d segments", inst, seg_valid[inst], n);
        end
      end
    end
  endtask

  task automatic wait_pos(input int p);
    for (int k = 0; k < D + 1 && (cyc % D) != p; k++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_directed_move();
    wait_pos(9);
    issue_move(2'd2, 1'b0);
    compared++;
    if ((cyc % D) != 10) begin
      mismatched++;
      $display("FAIL directed_ack_pos: got ack at pos %0d want pos 10", cyc % D);
    end
    finish_move(1'b0, 2'd0, 1'b0);
    @(negedge clk);
    #1;
    compared++;
    if (move_done[0] !== 1'b0 || length[0] !== 8'd3) begin
      mismatched++;
      $display("FAIL directed_after: done=%b length=%0d want 0 and 3", move_done[0], length[0]);
    end
    check_scan(0);
  endtask

  task automatic test_grow_hold();
    issue_move(2'd1, 1'b1);
    finish_move(1'b1, 2'd3, 1'b0);
    compared++;
    if (length[0] !== 8'd4) begin
      mismatched++;
      $display("FAIL grow_len: got length %0d want 4", length[0]);
    end
    if (move_ack[0] === 1'b1) model_accept(2'd3, 1'b0);
    finish_move(1'b0, 2'd0, 1'b0);
    check_scan(0);
  endtask

  task automatic test_full_grow();
    issue_move(2'd2, 1'b1);
    finish_move(1'b0, 2'd0, 1'b0);
    compared++;
    if (length[1] !== 8'd234 || full[1] !== 1'b1) begin
      mismatched++;
      $display("FAIL full_grow: length=%0d full=%b want 234 1", length[1], full[1]);
    end
    check_scan(1);
  endtask

  task automatic test_wrap_accept();
    int t;
    t = (m_head + D - 1) % D;
    wait_pos((t + D - 1) % D);
    issue_move(2'd3, 1'b0);
    finish_move(1'b0, 2'd0, 1'b0);
    check_scan(0);
  endtask

  task automatic test_random();
    int gap;
    bit keep;
    logic [1:0] d, d2;
    logic g, g2;
    for (int n = 0; n < 10; n++) begin
      gap = $urandom_range(0, 300);
      for (int k = 0; k < gap; k++) begin
        @(negedge clk);
        #1;
        compared++;
        if (move_done[0] !== 1'b0 || busy[0] !== 1'b0) begin
          mismatched++;
          $display("FAIL idle_gap: done=%b busy=%b want 0 0", move_done[0], busy[0]);
        end
      end
      d = 2'($urandom_range(0, 3));
      g = ($urandom_range(0, 2) == 0);
      d2 = 2'($urandom_range(0, 3));
      g2 = ($urandom_range(0, 1) == 0);
      keep = ($urandom_range(0, 3) == 0);
      issue_move(d, g);
      finish_move(keep, d2, g2);
      if (keep) begin
        if (move_ack[0] === 1'b1) model_accept(d2, g2);
        finish_move(1'b0, 2'd0, 1'b0);
      end
      check_scan(0);
      if (n % 4 == 3) check_scan(1);
    end
  endtask

  task automatic test_reset_armed();
    wait_pos(m_head);
    issue_move(2'd1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      move_req = 1'b0;
      #1;
      compared++;
      if (busy[0] !== 1'b1 || move_done[0] !== 1'b0) begin
        mismatched++;
        $display("FAIL armed_wait: busy=%b done=%b want 1 0", busy[0], move_done[0]);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (busy[i] !== 1'b1 || move_done[i] !== 1'b0 || seg_valid[i] !== 1'b0 || sr_in[i] !== 2'd0 ||
          length[i] !== ((i == 1) ? 8'd234 : 8'd3)) begin
        mismatched++;
        $display("FAIL armed_reset[%0d]: busy=%b done=%b valid=%b sr_in=%0d length=%0d", i, busy[i],
                 move_done[i], seg_valid[i], sr_in[i], length[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    for (int c = 0; c < D + 6; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      compared++;
      if (move_done[0] !== 1'b0 || move_done[1] !== 1'b0 || busy[0] !== (c < D)) begin
        mismatched++;
        $display("FAIL reinit c=%0d: done=%b/%b busy=%b want 0/0 %b", c, move_done[0], move_done[1], busy[0], c < D);
      end
    end
    compared++;
    if (length[0] !== 8'd3 || length[1] !== 8'd234) begin
      mismatched++;
      $display("FAIL reinit_len: got %0d/%0d want 3/234", length[0], length[1]);
    end
    check_scan(0);
  endtask

  initial begin
    test_reset();
    test_init();
    test_idle_scan();
    test_directed_move();
    test_grow_hold();
    test_full_grow();
    test_wrap_accept();
    test_random();
    test_reset_armed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/snake_body_ctrl.md
SNAKE_BODY_CTRL -- requirements
Module: snake_body_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the bits per body segment (direction code).
REQ-002 The block SHALL have parameter DEPTH, default 234, giving the entries in the attached shift register (in-to-out latency exactly DEPTH clocks).
REQ-003 The block SHALL have parameter INIT_LEN, default 3, giving the body length after initialisation (1..DEPTH).
REQ-004 The block SHALL have parameter INIT_DIR, default 0, giving the WIDTH-bit code written to every entry during initialisation.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 sr_in  output  WIDTH  data driven into the shift register input.
REQ-008 sr_out  input  WIDTH  data from the shift register output.
REQ-009 move_req  input  1  request to push a new head segment.
REQ-010 move_dir  input  WIDTH  direction code of the new head; sampled at acceptance.
REQ-011 move_grow  input  1  1 = keep tail (length+1); sampled at acceptance.
REQ-012 move_ack  output  1  one-cycle pulse: request accepted.
REQ-013 move_done  output  1  one-cycle pulse: new head written.
REQ-014 busy  output  1  high in INIT and ARMED.
REQ-015 length  output  $clog2(DEPTH+1)  current body length.
REQ-016 full  output  1  length == DEPTH.
REQ-017 seg_valid  output  1  body segment streaming on seg_dir.
REQ-018 seg_first  output  1  with seg_valid: segment is the head.
REQ-019 seg_dir  output  WIDTH  streamed segment code (equals sr_out).

Function
REQ-020 The block SHALL keep rotation counter pos, 0..DEPTH-1, incrementing every cycle and wrapping DEPTH-1 -> 0 in all states.
REQ-021 Ring entry k SHALL be the value driven on sr_in when pos==k; it reappears on sr_out when pos==k again.
REQ-022 Default sr_in SHALL equal sr_out (recirculate) in IDLE and ARMED, except at the write slot.
REQ-023 FSM states SHALL be INIT, IDLE, ARMED; INIT -> IDLE after DEPTH cycles; IDLE -> ARMED on acceptance; ARMED -> IDLE after write cycle.
REQ-024 In INIT, sr_in SHALL be INIT_DIR for every cycle, pos 0..DEPTH-1, then enter IDLE with pos==0.
REQ-025 move_req SHALL be accepted only in IDLE: move_ack pulses in that cycle; move_dir, move_grow and target = (head_ptr-1) mod DEPTH are latched.
REQ-026 move_req in INIT or ARMED SHALL be ignored; the requester holds it until move_ack.
REQ-027 In ARMED, in the cycle pos==target, sr_in SHALL equal the latched dir; on that edge head_ptr<=target, and length<=length+1 if grow and not full, else unchanged.
REQ-028 move_done SHALL pulse the cycle after the write; acceptance-to-done latency SHALL be 2..DEPTH+1 cycles.
REQ-029 If pos==target in the acceptance cycle itself, the write SHALL wait one full rotation (write only in ARMED).
REQ-030 Grow while full SHALL be treated as non-grow (oldest tail overwritten); full stays 1.
REQ-031 Scan: when pos==head_ptr (registered) in IDLE or ARMED and no scan active, seg_valid SHALL assert for exactly length consecutive cycles with seg_dir=sr_out, seg_first only on the first.
REQ-032 An active scan SHALL complete unaffected by a write; a head_ptr update SHALL take effect from the next scan start.
REQ-033 seg_valid SHALL stay 0 throughout INIT.

Reset
REQ-034 On rst_n=0, asynchronously: state=INIT, pos=0, head_ptr=0, length=INIT_LEN, sr_in=0, move_ack=0, move_done=0, seg_valid=0, seg_first=0, busy=1, full=(INIT_LEN==DEPTH).
REQ-035 Reset in any state, including ARMED or mid-scan, SHALL abandon the pending move (no move_done) and restart INIT.

Verification
REQ-036 Release reset -> busy=1 for 234 cycles, sr_in=INIT_DIR throughout; then IDLE, sr_in==sr_out, length=3.
REQ-037 After INIT, no move -> seg_valid at pos 0,1,2 each rotation, seg_first at pos 0, seg_dir=INIT_DIR.
REQ-038 IDLE, move_req dir=2 grow=0 at pos 10 -> ack that cycle; sr_in=2 at pos 233; done at pos 0; next scan starts pos 233, dir 2,0,0, length 3.
REQ-039 move with grow=1 -> length 4, next scan 4 segments; move_req held during ARMED -> single ack only after done.
REQ-040 INIT_LEN=234, grow=1 -> length stays 234, full=1, scan 234 segments with new head first.
REQ-041 Assert rst_n=0 while ARMED -> no move_done, INIT restarts, length=INIT_LEN.
